// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder
//
// Memory-side responder for the LC-3b CPU memory port. A request sampled in
// IDLE is latched, held for a fixed LATENCY, and then completed with a
// single-cycle mem_resp. Storage is a word-organised synchronous array with
// byte-lane write masking.
//
// Parameters
//   ADDR_BITS  word-index width; depth = 2**ADDR_BITS 16-bit words
//   LATENCY    cycles from request sampled in IDLE to mem_resp high (1..15)
//   INIT_FILE  preload image name; no preload is performed by this model
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp
//   mem_byte_enable  write lane mask: [0]=bits 7:0, [1]=bits 15:8
//   mem_address      byte address; word index = mem_address[ADDR_BITS:1]
//   mem_wdata        write data
//   mem_resp         completion strobe, one cycle per request
//   mem_rdata        read data, valid with mem_resp, holds afterwards
//   protocol_err     sticky: read and write sampled high together
//   rd_count         completed reads  (MEM_STATS_EN builds only, else 0)
//   wr_count         completed writes (MEM_STATS_EN builds only, else 0)
//
// Build option: define MEM_STATS_EN to build the completion counters.
// ---------------------------------------------------------------------------
module lc3b_mem_responder #(
   parameter int    ADDR_BITS = 10,
   parameter int    LATENCY   = 3,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        protocol_err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter value on the last BUSY cycle.
   localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

   state_t                 state, next_state;
   logic [3:0]             counter;
   logic                   lat_write;
   logic [ADDR_BITS-1:0]   lat_idx;
   logic [15:0]            lat_wdata;
   logic [1:0]             lat_mask;

   logic                   req;
   logic [ADDR_BITS-1:0]   in_idx;
   logic [ADDR_BITS-1:0]   rd_idx;
   logic                   load_rdata;

   logic [15:0]            mem_array [2**ADDR_BITS];

   // Upper address bits and the byte-select bit alias onto the same word.
   logic                   unused_addr;
   assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

   assign req    = mem_read | mem_write;
   assign in_idx = mem_address[ADDR_BITS:1];

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state logic. Dropping both request lines while BUSY aborts.
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (req) next_state = (LATENCY == 1) ? RESP : BUSY;
         BUSY: begin
            if (!req)                    next_state = IDLE;
            else if (counter == CNT_LAST) next_state = RESP;
         end
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output / datapath control. Read data is fetched on the edge entering
   // RESP; from IDLE (LATENCY==1) the live request is used since nothing is
   // latched yet. Write wins when both request lines are high.
   always_comb begin
      mem_resp   = (state == RESP);
      rd_idx     = (state == IDLE) ? in_idx : lat_idx;
      load_rdata = (next_state == RESP) &&
                   ((state == IDLE) ? !mem_write : !lat_write);
   end

   // Request capture, latency counter, read data and error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter      <= '0;
         lat_write    <= 1'b0;
         lat_idx      <= '0;
         lat_wdata    <= '0;
         lat_mask     <= '0;
         mem_rdata    <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (state == IDLE && req) begin
            lat_write <= mem_write;
            lat_idx   <= in_idx;
            lat_wdata <= mem_wdata;
            lat_mask  <= mem_byte_enable;
            counter   <= 4'd1;
            if (mem_read && mem_write) protocol_err <= 1'b1;
         end else if (state == BUSY) begin
            counter <= counter + 4'd1;
         end
         if (load_rdata) mem_rdata <= mem_array[rd_idx];
      end
   end

   // Array write, committed on the edge that ends RESP. An asynchronous
   // reset forces IDLE, so an interrupted transaction never reaches here.
   // NOTE: the array is deliberately not reset: contents survive reset and
   // the storage can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (state == RESP && lat_write) begin
         if (lat_mask[0]) mem_array[lat_idx][7:0]  <= lat_wdata[7:0];
         if (lat_mask[1]) mem_array[lat_idx][15:8] <= lat_wdata[15:8];
      end
   end

`ifdef MEM_STATS_EN
   // Completion counters; aborted requests never reach RESP. Wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (state == RESP) begin
         if (lat_write) wr_count <= wr_count + 16'd1;
         else           rd_count <= rd_count + 16'd1;
      end
   end
`else
   assign rd_count = 16'h0000;
   assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lc3b_mem_responder
//
// Self-checking bench for lc3b_mem_responder. A LATENCY=3 instance takes the
// directed scenarios plus a randomized run checked against a word-array
// reference model; a LATENCY=1 instance takes the back-to-back scenario.
// ---------------------------------------------------------------------------
module tb_lc3b_mem_responder;

   localparam int LAT0  = 3;
   localparam int DEPTH = 1024;

   logic        clk;
   logic        reset_n;

   logic        mem_read, mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address, mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        protocol_err;
   logic [15:0] rd_count, wr_count;

   logic        r1_read, r1_write;
   logic [1:0]  r1_be;
   logic [15:0] r1_address, r1_wdata;
   logic        r1_resp;
   logic [15:0] r1_rdata;
   logic        r1_err;
   logic [15:0] r1_rd_count, r1_wr_count;

   lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT0)) u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .protocol_err    (protocol_err),
      .rd_count        (rd_count),
      .wr_count        (wr_count)
   );

   lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut_l1 (
      .clk             (clk),
      .reset_n         (reset_n),
      .mem_read        (r1_read),
      .mem_write       (r1_write),
      .mem_byte_enable (r1_be),
      .mem_address     (r1_address),
      .mem_wdata       (r1_wdata),
      .mem_resp        (r1_resp),
      .mem_rdata       (r1_rdata),
      .protocol_err    (r1_err),
      .rd_count        (r1_rd_count),
      .wr_count        (r1_wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: word array with per-lane "known" flags.
   logic [15:0] model_mem [DEPTH];
   logic [1:0]  model_vld [DEPTH];
   logic [15:0] last_rdata;
   int          exp_rd, exp_wr;
   int          checks, passed;

`ifdef MEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int widx(input logic [15:0] addr);
      return (int'(addr) / 2) % DEPTH;
   endfunction

   // One complete transaction on the LATENCY=3 instance, checked against
   // the model; the model is updated on completion.
   task automatic xact(input string tag, input logic rd, input logic wr,
                       input logic [1:0] be, input logic [15:0] addr,
                       input logic [15:0] wd, output logic [15:0] rd_out);
      int lat;
      int idx;
      lat    = -1;
      rd_out = 'x;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; mem_byte_enable = be;
      mem_address = addr; mem_wdata = wd;
      for (int n = 0; n <= LAT0 + 4; n++) begin
         @(negedge clk);
         if (mem_resp === 1'b1) begin
            lat    = n;
            rd_out = mem_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check({tag, "_resp_one_cycle"}, 32'(mem_resp), 32'd0);
      check({tag, "_latency"}, lat, LAT0);
      idx = widx(addr);
      if (wr) begin
         if (be[0]) begin model_mem[idx][7:0]  = wd[7:0];  model_vld[idx][0] = 1'b1; end
         if (be[1]) begin model_mem[idx][15:8] = wd[15:8]; model_vld[idx][1] = 1'b1; end
         exp_wr = exp_wr + 1;
         check({tag, "_rdata_hold"}, 32'(mem_rdata), 32'(last_rdata));
      end else begin
         if (model_vld[idx] == 2'b11)
            check({tag, "_rdata"}, 32'(rd_out), 32'(model_mem[idx]));
         last_rdata = rd_out;
         exp_rd     = exp_rd + 1;
      end
   endtask

   // Request raised in cycle 0 and dropped in cycle 1: must never respond.
   task automatic aborted(input string tag, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wd);
      int resps;
      resps = 0;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; mem_byte_enable = 2'b11;
      mem_address = addr; mem_wdata = wd;
      @(negedge clk);
      if (mem_resp === 1'b1) resps++;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (mem_resp === 1'b1) resps++;
      end
      check({tag, "_no_resp"}, resps, 0);
      check({tag, "_rdata_hold"}, 32'(mem_rdata), 32'(last_rdata));
   endtask

   logic [15:0] rv;
   logic [15:0] addr;
   int          idx;

   initial begin
      checks = 0; passed = 0;
      exp_rd = 0; exp_wr = 0;
      last_rdata = 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = 16'h0000;
         model_vld[i] = 2'b00;
      end
      mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
      mem_address = 16'h0000; mem_wdata = 16'h0000;
      r1_read = 1'b0; r1_write = 1'b0; r1_be = 2'b00;
      r1_address = 16'h0000; r1_wdata = 16'h0000;

      // Reset state.
      reset_n = 1'b0;
      #22;
      check("rst_resp", 32'(mem_resp), 32'd0);
      check("rst_rdata", 32'(mem_rdata), 32'h0000);
      check("rst_err", 32'(protocol_err), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_wr_count", 32'(wr_count), 32'd0);
      reset_n = 1'b1;

      // Back-to-back reads with LATENCY=1: resp every second cycle.
      @(posedge clk); #1;
      r1_read = 1'b1; r1_address = 16'h0040;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check($sformatf("b2b_resp_c%0d", n), 32'(r1_resp), 32'(n % 2));
      end
      @(posedge clk); #1;
      r1_read = 1'b0;
      @(negedge clk);
      check("b2b_idle_after", 32'(r1_resp), 32'd0);
      check("b2b_rd_count", 32'(r1_rd_count), STATS ? 32'd4 : 32'd0);
      check("b2b_wr_count", 32'(r1_wr_count), 32'd0);
      check("b2b_err", 32'(r1_err), 32'd0);

      // Basic write then read.
      xact("t1_wr", 1'b0, 1'b1, 2'b11, 16'h0040, 16'hBEEF, rv);
      xact("t1_rd", 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, rv);
      check("t1_beef", 32'(rv), 32'hBEEF);

      // Byte-lane masking.
      xact("t2_init", 1'b0, 1'b1, 2'b11, 16'h0010, 16'h1234, rv);
      xact("t2_hi",   1'b0, 1'b1, 2'b10, 16'h0010, 16'hAB00, rv);
      xact("t2_rd1",  1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, rv);
      check("t2_ab34", 32'(rv), 32'hAB34);
      xact("t2_lo",   1'b0, 1'b1, 2'b01, 16'h0010, 16'h00CD, rv);
      xact("t2_rd2",  1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, rv);
      check("t2_abcd", 32'(rv), 32'hABCD);
      xact("t2_none", 1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, rv);
      xact("t2_rd3",  1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, rv);
      check("t2_unchanged", 32'(rv), 32'hABCD);

      // Aborted requests.
      aborted("t3_abort_rd", 1'b1, 1'b0, 16'h0040, 16'h0000);
      xact("t3_rd", 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, rv);
      check("t3_beef", 32'(rv), 32'hBEEF);
      aborted("t3_abort_wr", 1'b0, 1'b1, 16'h0040, 16'h1111);
      xact("t3_rd2", 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, rv);
      check("t3_beef2", 32'(rv), 32'hBEEF);

      // Read and write together: treated as a write, sticky error.
      xact("t4_both", 1'b1, 1'b1, 2'b11, 16'h0020, 16'h5A5A, rv);
      check("t4_err_set", 32'(protocol_err), 32'd1);
      xact("t4_rd", 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, rv);
      check("t4_5a5a", 32'(rv), 32'h5A5A);
      check("t4_err_sticky", 32'(protocol_err), 32'd1);
      check("t4_rd_count", 32'(rd_count), STATS ? 32'(exp_rd) : 32'd0);
      check("t4_wr_count", 32'(wr_count), STATS ? 32'(exp_wr) : 32'd0);

      // Reset in the middle of a write to the same word.
      @(posedge clk); #1;
      mem_write = 1'b1; mem_byte_enable = 2'b11;
      mem_address = 16'h0020; mem_wdata = 16'h0F0F;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("t4_rst_resp", 32'(mem_resp), 32'd0);
      check("t4_rst_err", 32'(protocol_err), 32'd0);
      check("t4_rst_rdata", 32'(mem_rdata), 32'h0000);
      check("t4_rst_rd_count", 32'(rd_count), 32'd0);
      mem_write = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_rd = 0; exp_wr = 0; last_rdata = 16'h0000;
      xact("t4_post_rd", 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, rv);
      check("t4_array_kept", 32'(rv), 32'h5A5A);
      check("t4_err_clear", 32'(protocol_err), 32'd0);

      // Address aliasing.
      xact("t6_wr", 1'b0, 1'b1, 2'b11, 16'h0802, 16'h7777, rv);
      xact("t6_rd_a", 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, rv);
      check("t6_alias_2", 32'(rv), 32'h7777);
      xact("t6_rd_b", 1'b1, 1'b0, 2'b00, 16'h0003, 16'h0000, rv);
      check("t6_alias_3", 32'(rv), 32'h7777);

      // Randomized traffic over a small aliased window.
      for (int i = 0; i < 30; i++) begin
         addr = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 31) << 1) |
                    ($urandom & 1));
         idx  = widx(addr);
         if (model_vld[idx] == 2'b11 && ($urandom & 1) == 1)
            xact($sformatf("rnd%0d_rd", i), 1'b1, 1'b0, 2'b00, addr, 16'h0000, rv);
         else
            xact($sformatf("rnd%0d_wr", i), 1'b0, 1'b1, 2'($urandom_range(0, 3)),
                 addr, 16'($urandom), rv);
      end
      check("rnd_err", 32'(protocol_err), 32'd0);
      check("rnd_rd_count", 32'(rd_count), STATS ? 32'(exp_rd) : 32'd0);
      check("rnd_wr_count", 32'(wr_count), STATS ? 32'(exp_wr) : 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
